// File: rtl/Pipe_Buf_Reg_PKG.sv
// Shared pipeline-buffer definitions for the 5-stage RISC-V core.
// Holds the halt sequencer state encoding, the bundled hazard control
// word used by the top-level pipeline wiring, the register-field
// positions inside a 32-bit instruction, and the load-use detector.
package Pipe_Buf_Reg_PKG;

    // Register source field positions inside the instruction word
    localparam int RS1_LSB = 15;
    localparam int RS1_MSB = 19;
    localparam int RS2_LSB = 20;
    localparam int RS2_MSB = 24;

    // Halt sequencer states
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } halt_state_e;

    // Stall / flush enables for PC, IF/ID and ID/EX
    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_flush;
    } hazard_ctrl_t;

    // Free-running pipeline
    localparam hazard_ctrl_t CTRL_NORMAL = '{pc_write: 1'b1, if_id_write: 1'b1,
                                             if_id_flush: 1'b0, id_ex_flush: 1'b0};
    // Redirect: fetch the new target, squash the two younger instructions
    localparam hazard_ctrl_t CTRL_BRANCH = '{pc_write: 1'b1, if_id_write: 1'b1,
                                             if_id_flush: 1'b1, id_ex_flush: 1'b1};
    // Load-use: hold PC and IF/ID, insert one bubble into EX
    localparam hazard_ctrl_t CTRL_STALL  = '{pc_write: 1'b0, if_id_write: 1'b0,
                                             if_id_flush: 1'b0, id_ex_flush: 1'b1};
    // Halt / reset: nothing new enters, front end is emptied
    localparam hazard_ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, if_id_write: 1'b0,
                                             if_id_flush: 1'b1, id_ex_flush: 1'b1};

    // Load in EX whose destination feeds an rs field of the instruction in ID.
    // No opcode filtering: an unused rs field may cause a harmless extra stall.
    function automatic logic load_use_hit(input logic        memread,
                                          input logic [4:0]  rd,
                                          input logic [31:0] instr);
        logic [4:0] rs1_v;
        logic [4:0] rs2_v;
        rs1_v = instr[RS1_MSB:RS1_LSB];
        rs2_v = instr[RS2_MSB:RS2_LSB];
        return memread && (rd != 5'd0) && ((rd == rs1_v) || (rd == rs2_v));
    endfunction

endpackage

// File: rtl/hazard_halt_unit_sat_counter.sv
// Saturating event counter.
// Ports: clk, reset (sync, active-high), inc (count one event this cycle),
//        count (registered value, sticks at all-ones).
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_r;

    // Event accumulator, holds at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= '0;
        end else if (inc && (count_r != {WIDTH{1'b1}})) begin
            count_r <= count_r + WIDTH'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/hazard_halt_unit.sv
// Pipeline hazard and halt control for the 5-stage RISC-V core.
// Detects load-use hazards, squashes on taken branches/jumps, and sequences
// a halt: the halt instruction in EX freezes the front end, MEM/WB drain for
// DRAIN_CYCLES, then `halted` asserts and the core stays frozen until reset.
// Ports:
//   clk, reset           core clock, synchronous active-high reset
//   if_id_instr          instruction in ID (rs1/rs2 fields used)
//   id_ex_memread/rd     load flag and destination of instruction in EX
//   id_ex_halt           halt instruction is in EX
//   ex_branch_taken      EX redirects the PC this cycle
//   pc_write, if_id_write, if_id_flush, id_ex_flush   combinational controls
//   halted               registered, core drained and frozen
//   stall_count, flush_count   registered saturating performance counters
module hazard_halt_unit
    import Pipe_Buf_Reg_PKG::*;
#(
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      if_id_instr,
    input  logic             id_ex_memread,
    input  logic [4:0]       id_ex_rd,
    input  logic             id_ex_halt,
    input  logic             ex_branch_taken,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

    halt_state_e        state_r;
    halt_state_e        state_next_s;
    logic [DRAIN_W-1:0] drain_cnt_r;
    logic [DRAIN_W-1:0] drain_cnt_next_s;
    logic               halted_r;
    hazard_ctrl_t       ctrl_s;
    logic               load_use_s;
    logic               stall_inc_s;
    logic               flush_inc_s;

    assign load_use_s = load_use_hit(id_ex_memread, id_ex_rd, if_id_instr);

    // Next-state, drain counting, control outputs and counter increments
    always_comb begin
        state_next_s     = state_r;
        drain_cnt_next_s = drain_cnt_r;
        ctrl_s           = CTRL_NORMAL;
        stall_inc_s      = 1'b0;
        flush_inc_s      = 1'b0;
        if (reset) begin
            // Controls act in the same cycle, so hold the pipe empty during reset
            ctrl_s           = CTRL_FREEZE;
            state_next_s     = RUN;
            drain_cnt_next_s = '0;
        end else begin
            case (state_r)
                RUN: begin
                    if (id_ex_halt) begin
                        // A halt in EX outranks a redirect resolved alongside it
                        ctrl_s           = CTRL_FREEZE;
                        state_next_s     = DRAIN;
                        drain_cnt_next_s = '0;
                    end else if (ex_branch_taken) begin
                        // The squash also removes the stalled consumer; no stall counted
                        ctrl_s      = CTRL_BRANCH;
                        flush_inc_s = 1'b1;
                    end else if (load_use_s) begin
                        // Bubble clears id_ex_memread, so this lasts one cycle
                        ctrl_s      = CTRL_STALL;
                        stall_inc_s = 1'b1;
                    end else begin
                        ctrl_s = CTRL_NORMAL;
                    end
                end
                DRAIN: begin
                    ctrl_s = CTRL_FREEZE;
                    if (drain_cnt_r == DRAIN_LAST) begin
                        state_next_s     = HALT;
                        drain_cnt_next_s = '0;
                    end else begin
                        drain_cnt_next_s = drain_cnt_r + DRAIN_W'(1);
                    end
                end
                HALT: begin
                    ctrl_s = CTRL_FREEZE;
                end
                default: begin
                    ctrl_s           = CTRL_FREEZE;
                    state_next_s     = RUN;
                    drain_cnt_next_s = '0;
                end
            endcase
        end
    end

    // State, drain counter and halted flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= RUN;
            drain_cnt_r <= '0;
            halted_r    <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            drain_cnt_r <= drain_cnt_next_s;
            // Rises on the same edge that enters HALT, then holds there
            halted_r    <= (state_next_s == HALT);
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc_s),
        .count (stall_count)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc_s),
        .count (flush_count)
    );

    assign pc_write    = ctrl_s.pc_write;
    assign if_id_write = ctrl_s.if_id_write;
    assign if_id_flush = ctrl_s.if_id_flush;
    assign id_ex_flush = ctrl_s.id_ex_flush;
    assign halted      = halted_r;

endmodule
